// File: rtl/smem_irq_scheduler.sv
// Secure-ROM residency monitor: tracks entry/exit of the secure code region,
// defers peripheral interrupts while it runs and raises a fault reset on misuse.
module smem_irq_scheduler #(
   parameter logic [15:0] SMEM_BASE      = 16'hA100,
   parameter logic [15:0] LAST_SMEM_ADDR = 16'hBFFE,
   parameter logic [15:0] RESET_HANDLER  = 16'hFFFE,
   parameter logic [15:0] MAX_CYCLES     = 16'd1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc,
   input  logic        irq_in,
   input  logic        irq_ack,
   output logic        irq_out,
   output logic        smem_busy,
   output logic        wdt_reset,
   output logic [3:0]  defer_cnt
);

   typedef enum logic [1:0] {IDLE, ACTIVE, EXIT, FAULT} state_t;

   state_t      state_reg, state_next;
   logic [15:0] wdt_cnt_reg;
   logic        pending_reg, pending_next;
   logic        irq_out_reg, irq_out_next;
   logic        irq_in_d_reg;
   logic        smem_busy_reg;
   logic        wdt_reset_reg;
   logic [3:0]  defer_cnt_reg;

   logic in_smem, entry, is_last, wdt_expired, irq_rise;

   assign in_smem     = (pc >= SMEM_BASE) && (pc <= LAST_SMEM_ADDR);
   assign entry       = (pc == SMEM_BASE);
   assign is_last     = (pc == LAST_SMEM_ADDR);
   assign wdt_expired = (wdt_cnt_reg == MAX_CYCLES);
   assign irq_rise    = irq_in && !irq_in_d_reg;

   // Watchdog expiry outranks reaching the last address.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (entry)
               state_next = ACTIVE;
            else if (in_smem)
               state_next = FAULT;
         end
         ACTIVE: begin
            if (!in_smem || wdt_expired)
               state_next = FAULT;
            else if (is_last)
               state_next = EXIT;
         end
         EXIT: begin
            if (!in_smem)
               state_next = IDLE;
            else if (!is_last)
               state_next = FAULT;
         end
         FAULT: begin
            if (pc == RESET_HANDLER)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Requests are only released while the block sits in IDLE and stays there;
   // an acknowledge that coincides with a fresh edge keeps that edge pending.
   always_comb begin
      pending_next = pending_reg;
      irq_out_next = 1'b0;
      if (state_next == FAULT && state_reg != FAULT)
         pending_next = 1'b0;
      else if (state_reg != IDLE) begin
         if (irq_in)
            pending_next = 1'b1;
      end
      else if (irq_ack)
         pending_next = irq_rise;
      else if (state_next == IDLE)
         irq_out_next = pending_reg || irq_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         wdt_cnt_reg   <= 16'd0;
         pending_reg   <= 1'b0;
         irq_out_reg   <= 1'b0;
         irq_in_d_reg  <= 1'b0;
         smem_busy_reg <= 1'b0;
         wdt_reset_reg <= 1'b0;
         defer_cnt_reg <= 4'd0;
      end
      else begin
         state_reg     <= state_next;
         pending_reg   <= pending_next;
         irq_out_reg   <= irq_out_next;
         irq_in_d_reg  <= irq_in;
         smem_busy_reg <= (state_next == ACTIVE) || (state_next == EXIT);
         wdt_reset_reg <= (state_next == FAULT) && (pc != RESET_HANDLER);

         if (state_reg == IDLE && state_next == ACTIVE)
            wdt_cnt_reg <= 16'd0;
         else if (state_reg == ACTIVE)
            wdt_cnt_reg <= wdt_cnt_reg + 16'd1;

         if (irq_rise && (state_reg == ACTIVE || state_reg == EXIT) &&
             defer_cnt_reg != 4'hF)
            defer_cnt_reg <= defer_cnt_reg + 4'd1;
      end
   end

   assign irq_out   = irq_out_reg;
   assign smem_busy = smem_busy_reg;
   assign wdt_reset = wdt_reset_reg;
   assign defer_cnt = defer_cnt_reg;

endmodule

// File: tb/tb_smem_irq_scheduler.sv
// Directed bench for smem_irq_scheduler: region tracking, deferral, watchdog and reset.
module tb_smem_irq_scheduler;

   logic        clk;
   logic        rst;
   logic [15:0] pc;
   logic        irq_in;
   logic        irq_ack;
   logic        irq_out, smem_busy, wdt_reset;
   logic [3:0]  defer_cnt;
   logic        irq_out8, smem_busy8, wdt_reset8;
   logic [3:0]  defer_cnt8;

   int checks = 0;
   int errors = 0;

   smem_irq_scheduler dut (
      .clk(clk), .rst(rst), .pc(pc), .irq_in(irq_in), .irq_ack(irq_ack),
      .irq_out(irq_out), .smem_busy(smem_busy), .wdt_reset(wdt_reset),
      .defer_cnt(defer_cnt)
   );

   smem_irq_scheduler #(.MAX_CYCLES(16'd8)) dut8 (
      .clk(clk), .rst(rst), .pc(pc), .irq_in(irq_in), .irq_ack(irq_ack),
      .irq_out(irq_out8), .smem_busy(smem_busy8), .wdt_reset(wdt_reset8),
      .defer_cnt(defer_cnt8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
      else
         $display("ok   %s = %0h", tag, got);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic io, input logic sb,
                            input logic wr, input logic [3:0] dc);
      check_eq({tag, ".irq_out"}, {15'd0, irq_out}, {15'd0, io});
      check_eq({tag, ".smem_busy"}, {15'd0, smem_busy}, {15'd0, sb});
      check_eq({tag, ".wdt_reset"}, {15'd0, wdt_reset}, {15'd0, wr});
      check_eq({tag, ".defer_cnt"}, {12'd0, defer_cnt}, {12'd0, dc});
   endtask

   initial begin
      rst = 1'b1; pc = 16'h0000; irq_in = 1'b0; irq_ack = 1'b0;
      step(); step();
      check_all("reset", 1'b0, 1'b0, 1'b0, 4'd0);
      rst = 1'b0;

      // Case 1: clean pass through the region
      pc = 16'h4000; step();
      check_eq("c1.idle_busy", {15'd0, smem_busy}, 16'd0);
      pc = 16'hA100; step();
      check_eq("c1.entry_busy", {15'd0, smem_busy}, 16'd1);
      pc = 16'hA200;
      for (int i = 0; i < 10; i++) begin
         step();
         check_eq($sformatf("c1.body%0d_busy", i), {15'd0, smem_busy}, 16'd1);
         check_eq($sformatf("c1.body%0d_wdt", i), {15'd0, wdt_reset}, 16'd0);
      end
      pc = 16'hBFFE; step();
      check_all("c1.last", 1'b0, 1'b1, 1'b0, 4'd0);
      pc = 16'hC000; step();
      check_all("c1.out", 1'b0, 1'b0, 1'b0, 4'd0);

      // Case 2: deferred interrupt released after exit
      pc = 16'hA100; step();
      pc = 16'hA200; irq_in = 1'b1; step();
      check_eq("c2.defer_irq_out", {15'd0, irq_out}, 16'd0);
      irq_in = 1'b0; step();
      check_all("c2.deferred", 1'b0, 1'b1, 1'b0, 4'd1);
      pc = 16'hBFFE; step();
      check_eq("c2.exit_irq_out", {15'd0, irq_out}, 16'd0);
      pc = 16'hC000; step();
      check_all("c2.idle0", 1'b0, 1'b0, 1'b0, 4'd1);
      step();
      check_eq("c2.released", {15'd0, irq_out}, 16'd1);
      irq_ack = 1'b1; step();
      check_eq("c2.acked", {15'd0, irq_out}, 16'd0);
      irq_ack = 1'b0; step();
      check_eq("c2.quiet", {15'd0, irq_out}, 16'd0);

      // Acknowledge coinciding with a fresh edge keeps the new request
      pc = 16'hA100; step();
      pc = 16'hA200; irq_in = 1'b1; step();
      irq_in = 1'b0; step();
      check_eq("sim.defer_cnt", {12'd0, defer_cnt}, 16'd2);
      pc = 16'hBFFE; step();
      pc = 16'hC000; step();
      step();
      check_eq("sim.released", {15'd0, irq_out}, 16'd1);
      irq_ack = 1'b1; irq_in = 1'b1; step();
      check_eq("sim.ack_edge", {15'd0, irq_out}, 16'd0);
      irq_ack = 1'b0; irq_in = 1'b0; step();
      check_eq("sim.reassert", {15'd0, irq_out}, 16'd1);
      irq_ack = 1'b1; step();
      check_eq("sim.ack2", {15'd0, irq_out}, 16'd0);
      irq_ack = 1'b0; step();
      check_all("sim.done", 1'b0, 1'b0, 1'b0, 4'd2);

      // Region boundaries just outside the window do not fault
      pc = 16'hBFFF; step();
      check_eq("edge.bfff_wdt", {15'd0, wdt_reset}, 16'd0);
      pc = 16'hA0FF; step();
      check_eq("edge.a0ff_wdt", {15'd0, wdt_reset}, 16'd0);

      // Case 3: jump into the middle of the region
      pc = 16'h4000; step();
      pc = 16'hA300; step();
      check_all("c3.fault", 1'b0, 1'b0, 1'b1, 4'd2);
      pc = 16'h1234; step();
      check_eq("c3.hold_wdt", {15'd0, wdt_reset}, 16'd1);
      pc = 16'hFFFE; step();
      check_all("c3.recovered", 1'b0, 1'b0, 1'b0, 4'd2);
      step();
      check_eq("c3.stay_idle", {15'd0, wdt_reset}, 16'd0);

      // Case 4: watchdog with MAX_CYCLES=8; expiry coincides with the last address
      rst = 1'b1; step(); rst = 1'b0;
      check_eq("c4.rst_defer", {12'd0, defer_cnt}, 16'd0);
      pc = 16'hA100; step();
      pc = 16'hA200;
      for (int i = 0; i < 8; i++) step();
      check_eq("c4.pre_wdt8", {15'd0, wdt_reset8}, 16'd0);
      check_eq("c4.pre_busy8", {15'd0, smem_busy8}, 16'd1);
      pc = 16'hBFFE; step();
      check_eq("c4.expired_wdt8", {15'd0, wdt_reset8}, 16'd1);
      check_eq("c4.expired_busy8", {15'd0, smem_busy8}, 16'd0);
      check_eq("c4.long_busy", {15'd0, smem_busy}, 16'd1);
      pc = 16'hFFFE; step();
      check_eq("c4.rec_wdt8", {15'd0, wdt_reset8}, 16'd0);
      check_eq("c4.main_busy", {15'd0, smem_busy}, 16'd0);

      // Case 5: defer counter saturates
      pc = 16'hA100; step();
      pc = 16'hA200;
      for (int i = 0; i < 20; i++) begin
         irq_in = 1'b1; step();
         irq_in = 1'b0; step();
         if (i == 13)
            check_eq("c5.defer14", {12'd0, defer_cnt}, 16'd14);
      end
      check_all("c5.saturated", 1'b0, 1'b1, 1'b0, 4'hF);

      // Case 6: reset mid-ACTIVE with a pending request
      rst = 1'b1; step();
      check_all("c6.reset", 1'b0, 1'b0, 1'b0, 4'd0);
      rst = 1'b0; pc = 16'hC000; step();
      check_eq("c6.no_pending0", {15'd0, irq_out}, 16'd0);
      step();
      check_eq("c6.no_pending1", {15'd0, irq_out}, 16'd0);
      pc = 16'hA100; step();
      check_all("c6.reentry", 1'b0, 1'b1, 1'b0, 4'd0);
      pc = 16'hA200; step();
      pc = 16'hBFFE; step();
      check_eq("c6.exit_busy", {15'd0, smem_busy}, 16'd1);
      pc = 16'hC000; step();
      check_all("c6.idle", 1'b0, 1'b0, 1'b0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
